sw_debounce: RTL and testbench

- Input-side conditioner for asynchronous board inputs: slide switches and push buttons.
- Per channel: synchronizes the raw level, filters contact bounce with a saturating counter, and produces a clean level plus one-cycle rise/fall pulses.
- Sits between the top-level pins and the video-controller control logic. It is the read side of the pin interface, complementing the LED drive side.

---
 rtl/sw_debounce.sv | 113 +++++++++++
 tb/tb_sw_debounce.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce
// ----------------------------------------------------------------------------
// Input conditioner for asynchronous board inputs (slide switches, push
// buttons). Every channel first passes through a flip-flop synchronizer. A
// saturating counter then filters contact bounce. The block produces a clean
// level and one-cycle rise/fall pulses. This is the read side of the pin
// interface and feeds the video-controller control logic.
//
// Parameters
//   N            number of independent input channels
//   CNT_W        debounce counter width; a change must persist for 2**CNT_W
//                qualifying (ce=1) cycles before it is accepted
//   SYNC_STAGES  synchronizer depth, 2 or 3
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous, active-high reset; clears all state
//   ce          count enable / prescale tick (tie high for full-rate filtering)
//   raw_in      [N] asynchronous input levels
//   level       [N] debounced, synchronized level
//   rise        [N] one-cycle pulse on each accepted 0->1 transition
//   fall        [N] one-cycle pulse on each accepted 1->0 transition
//   any_change  OR of all rise/fall bits, aligned with them
// ----------------------------------------------------------------------------
module sw_debounce #(
  parameter int N           = 2,
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ce,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         any_change
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Bit 0 is the first synchronizer stage. Bit SYNC_STAGES-1 is the
  // synchronized value that the filter uses.
  logic [SYNC_STAGES-1:0] sync_reg [N];
  logic [CNT_W-1:0]       cnt_reg  [N];
  logic [CNT_W-1:0]       cnt_next [N];

  logic [N-1:0] sync_s;
  logic [N-1:0] commit;
  logic [N-1:0] level_reg;
  logic [N-1:0] level_next;
  logic [N-1:0] rise_reg;
  logic [N-1:0] rise_next;
  logic [N-1:0] fall_reg;
  logic [N-1:0] fall_next;
  logic         any_change_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_ch
      logic mismatch;
      logic at_max;

      assign sync_s[gi] = sync_reg[gi][SYNC_STAGES-1];
      assign mismatch   = sync_s[gi] ^ level_reg[gi];
      assign at_max     = (cnt_reg[gi] == CNT_MAX);

      // The counter never wraps. Reaching MAX with ce high is the commit
      // point, and the counter restarts from zero on that same edge.
      assign commit[gi] = mismatch & ce & at_max;

      // Any agreement between input and level clears the count. A single
      // bounce therefore restarts the whole qualification window.
      assign cnt_next[gi] = !mismatch ? '0 :
                            !ce       ? cnt_reg[gi] :
                            at_max    ? '0 :
                                        cnt_reg[gi] + CNT_W'(1);

      assign level_next[gi] = level_reg[gi] ^ commit[gi];
      assign rise_next[gi]  = commit[gi] & sync_s[gi];
      assign fall_next[gi]  = commit[gi] & ~sync_s[gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        sync_reg[i] <= '0;
        cnt_reg[i]  <= '0;
      end
      level_reg      <= '0;
      rise_reg       <= '0;
      fall_reg       <= '0;
      any_change_reg <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        // The synchronizer runs every cycle, independent of ce.
        sync_reg[i] <= {sync_reg[i][SYNC_STAGES-2:0], raw_in[i]};
        cnt_reg[i]  <= cnt_next[i];
      end
      level_reg      <= level_next;
      rise_reg       <= rise_next;
      fall_reg       <= fall_next;
      any_change_reg <= |(rise_next | fall_next);
    end
  end

  assign level      = level_reg;
  assign rise       = rise_reg;
  assign fall       = fall_reg;
  assign any_change = any_change_reg;

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce with N=2, CNT_W=3, SYNC_STAGES=2.
// Inputs are driven 1 time unit after a rising edge. The expected outputs for
// the next edge are queued at that moment. They are popped and compared 1
// time unit after that edge.
module tb_sw_debounce;

  localparam int N     = 2;
  localparam int CNT_W = 3;
  localparam int SYNC  = 2;
  // Edge (counted from the one that first samples a new raw value) at which
  // the level changes.
  localparam int LAT   = SYNC - 1 + (1 << CNT_W);

  logic         CLK;
  logic         RST;
  logic         ce;
  logic [N-1:0] raw_in;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         any_change;

  sw_debounce #(
    .N(N),
    .CNT_W(CNT_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ce(ce),
    .raw_in(raw_in),
    .level(level),
    .rise(rise),
    .fall(fall),
    .any_change(any_change)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] lvl;
    logic [1:0] rs;
    logic [1:0] fl;
    logic       any;
    string      nm;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       ce;
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] rs;
    logic [1:0] fl;
    logic       any;
    string      nm;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // One clock transaction. Drive the inputs, queue the expected outputs,
  // advance one edge, then pop the entry and compare it.
  task automatic cyc(input logic r, input logic c, input logic [1:0] raw,
                     input logic [1:0] el, input logic [1:0] er,
                     input logic [1:0] ef, input logic ea, input string nm);
    exp_t e;
    RST    = r;
    ce     = c;
    raw_in = raw;
    sb.push_back('{lvl: el, rs: er, fl: ef, any: ea, nm: nm});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    checks++;
    cyc_no++;
    $display("cyc %0d %s rst=%b ce=%b raw=%b -> level=%b rise=%b fall=%b any=%b",
             cyc_no, e.nm, r, c, raw, level, rise, fall, any_change);
    if ({level, rise, fall, any_change} !== {e.lvl, e.rs, e.fl, e.any}) begin
      errors++;
      $display("FAIL %s: got level=%b rise=%b fall=%b any=%b, expected level=%b rise=%b fall=%b any=%b",
               e.nm, level, rise, fall, any_change, e.lvl, e.rs, e.fl, e.any);
    end
  endtask

  task automatic chk_cnt(input int ch, input int exp_v, input string nm);
    logic [CNT_W-1:0] got;
    got = dut.cnt_reg[ch];
    checks++;
    if (got !== CNT_W'(exp_v)) begin
      errors++;
      $display("FAIL %s: cnt[%0d]=%0d expected %0d", nm, ch, got, exp_v);
    end
  endtask

  // Expected output for edge k after a raw step from level 'old' toward 'nw'.
  task automatic step_exp(input int k, input logic [1:0] old, input logic [1:0] nw,
                          output logic [1:0] el, output logic [1:0] er,
                          output logic [1:0] ef, output logic ea);
    el = (k >= LAT) ? nw : old;
    er = (k == LAT) ? (nw & ~old) : 2'b00;
    ef = (k == LAT) ? (old & ~nw) : 2'b00;
    ea = (k == LAT) && (old != nw);
  endtask

  task automatic add_step_rows(input logic [1:0] raw, input logic [1:0] old,
                               input logic [1:0] nw, input int n, input string nm);
    logic [1:0] el, er, ef;
    logic       ea;
    for (int k = 0; k < n; k++) begin
      step_exp(k, old, nw, el, er, ef, ea);
      tbl.push_back('{rst: 1'b0, ce: 1'b1, raw: raw, lvl: el, rs: er, fl: ef, any: ea, nm: nm});
    end
  endtask

  task automatic settle(input logic [1:0] raw, input logic [1:0] old,
                        input logic [1:0] nw, input int n, input string nm);
    logic [1:0] el, er, ef;
    logic       ea;
    for (int k = 0; k < n; k++) begin
      step_exp(k, old, nw, el, er, ef, ea);
      cyc(1'b0, 1'b1, raw, el, er, ef, ea, nm);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time=%0t expected finish before 50000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int q;
    logic [1:0] el, er;
    logic       ea;

    RST    = 1'b1;
    ce     = 1'b1;
    raw_in = 2'b00;

    // Table: reset hold, first qualification after reset, release, clean step.
    for (int i = 0; i < 3; i++)
      tbl.push_back('{rst: 1'b1, ce: 1'b1, raw: 2'b11, lvl: 2'b00, rs: 2'b00,
                      fl: 2'b00, any: 1'b0, nm: "reset_hold"});
    add_step_rows(2'b11, 2'b00, 2'b11, LAT + 2, "post_reset");
    add_step_rows(2'b10, 2'b11, 2'b10, LAT + 2, "release");
    add_step_rows(2'b11, 2'b10, 2'b11, LAT + 2, "clean_step");
    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].rst, tbl[i].ce, tbl[i].raw, tbl[i].lvl, tbl[i].rs,
          tbl[i].fl, tbl[i].any, tbl[i].nm);

    // Bounce: level[0] back to 0, then raw[0] toggles 1,0,1,0 every 3 cycles.
    settle(2'b10, 2'b11, 2'b10, LAT + 2, "pre_bounce");
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 3; j++)
        cyc(1'b0, 1'b1, (b % 2 == 0) ? 2'b11 : 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, "bounce");
    settle(2'b11, 2'b10, 2'b11, LAT + 3, "bounce_final");

    // Prescale: level[1] to 0, then raw[1] steps up with ce high one cycle in four.
    settle(2'b01, 2'b11, 2'b01, LAT + 2, "pre_prescale");
    q = 0;
    for (int k = 0; k < 36; k++) begin
      logic c;
      c = (k % 4 == 0);
      if (k >= 2 && c) q++;
      el = (k >= 32) ? 2'b11 : 2'b01;
      er = (k == 32) ? 2'b10 : 2'b00;
      ea = (k == 32);
      cyc(1'b0, c, 2'b11, el, er, 2'b00, ea, "prescale");
      chk_cnt(1, (k >= 32) ? 0 : q, "prescale_cnt");
      chk_cnt(0, 0, "prescale_cnt0");
    end

    // Reset mid-count: cnt[0] reaches 5, then a reset discards the count.
    settle(2'b10, 2'b11, 2'b10, LAT + 2, "pre_midreset");
    for (int k = 0; k < 7; k++)
      cyc(1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, "midcount");
    chk_cnt(0, 5, "midcount_cnt");
    cyc(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, "midreset");
    chk_cnt(0, 0, "midreset_cnt0");
    chk_cnt(1, 0, "midreset_cnt1");
    settle(2'b11, 2'b00, 2'b11, LAT + 3, "post_midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
